// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation encodings, the
// sequencing state enum, NZCV flag bit positions and overflow helpers.
// Imported by alu_pipe and alu_mul_iter.
package alu_pkg;

  // Operation encodings on alu_op
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ORR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  // Control sequencing states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } alu_state_e;

  // Bit positions inside the internal 4-bit NZCV bus
  localparam int NZCV_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Signed overflow for A+B(+cin): operands agree in sign, result differs
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow for A-B: operands differ in sign, result differs from A
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock.
// A start pulse loads the operands; WIDTH iterations follow. done is high
// during the final iteration cycle, so product is complete right after the
// edge on which done was seen.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             load operands and begin (ignored fields when busy)
//   a, b              unsigned operands
//   busy              iterations in progress
//   done              final iteration occurs on the coming edge
//   product           low WIDTH bits of a*b
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;

  // Operand load and shift-add iteration; bits shifted out of a_r only
  // contribute above WIDTH and are intentionally dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_r   <= '0;
      count_r <= '0;
      busy_r  <= 1'b0;
    end else if (start) begin
      a_r     <= a;
      b_r     <= b;
      acc_r   <= '0;
      count_r <= '0;
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      if (b_r[0]) begin
        acc_r <= acc_r + a_r;
      end
      a_r <= a_r << 1;
      b_r <= b_r >> 1;
      if (count_r == LAST_CNT) begin
        busy_r  <= 1'b0;
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r && (count_r == LAST_CNT);
  assign product = acc_r;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and full ARM NZCV flags.
// Single-cycle ops produce their result on the accepting edge; results and
// flags are held until the consumer takes them.
// Optional feature macro: ALU_MUL_EN -- when defined, op MUL uses the
// iterative multiplier (WIDTH+1 cycle latency); when undefined, MUL
// completes in one cycle with result 0 and Z=1.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake (src_a, src_b, alu_op, carry_in)
//   out_valid / out_ready output handshake (result, flag_n/z/c/v)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [2:0]       alu_op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  alu_state_e        state_r;
  logic              out_valid_r;
  logic [WIDTH-1:0]  result_r;
  logic [NZCV_W-1:0] nzcv_r;

  logic              in_ready_s;
  logic              accept_s;
  logic              take_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  res_s;
  logic [NZCV_W-1:0] nzcv_s;
  logic              c_s;
  logic              v_s;

  assign in_ready_s = (state_r == S_IDLE) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign take_s     = out_valid_r && out_ready;

`ifdef ALU_MUL_EN
  logic              mul_start_s;
  logic              mul_busy_s;
  logic              mul_done_s;
  logic [WIDTH-1:0]  mul_product_s;
  logic [NZCV_W-1:0] mul_nzcv_s;

  assign mul_start_s = accept_s && (alu_op == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start_s),
    .a      (src_a),
    .b      (src_b),
    .busy   (mul_busy_s),
    .done   (mul_done_s),
    .product(mul_product_s)
  );

  // Flags for a finished multiply: only N and Z are meaningful
  always_comb begin
    mul_nzcv_s         = '0;
    mul_nzcv_s[FLAG_N] = mul_product_s[WIDTH-1];
    mul_nzcv_s[FLAG_Z] = (mul_product_s == '0);
  end
`endif

  // Single-cycle datapath: result plus carry/overflow from a WIDTH+1 bit sum
  always_comb begin
    sum_s = '0;
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (alu_op)
      OP_AND: res_s = src_a & src_b;
      OP_ORR: res_s = src_a | src_b;
      OP_EOR: res_s = src_a ^ src_b;
      OP_MOV: res_s = src_b;
      OP_ADD: begin
        sum_s = {1'b0, src_a} + {1'b0, src_b};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(src_a[WIDTH-1], src_b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_ADC: begin
        sum_s = {1'b0, src_a} + {1'b0, src_b} + {{WIDTH{1'b0}}, carry_in};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(src_a[WIDTH-1], src_b[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is NOT borrow, i.e. A >= B unsigned
        sum_s = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = sub_ovf(src_a[WIDTH-1], src_b[WIDTH-1], sum_s[WIDTH-1]);
      end
      // Without the multiplier, MUL yields zero; with it, this path is unused
      OP_MUL: res_s = '0;
      default: res_s = '0;
    endcase
    nzcv_s         = '0;
    nzcv_s[FLAG_N] = res_s[WIDTH-1];
    nzcv_s[FLAG_Z] = (res_s == '0);
    nzcv_s[FLAG_C] = c_s;
    nzcv_s[FLAG_V] = v_s;
  end

  // Sequencing FSM with the registered result, flags and out_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      nzcv_r      <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
`ifdef ALU_MUL_EN
            if (alu_op == OP_MUL) begin
              // Any previous result was taken in this same cycle
              state_r     <= S_MUL;
              out_valid_r <= 1'b0;
            end else begin
              result_r    <= res_s;
              nzcv_r      <= nzcv_s;
              out_valid_r <= 1'b1;
            end
`else
            result_r    <= res_s;
            nzcv_r      <= nzcv_s;
            out_valid_r <= 1'b1;
`endif
          end else if (take_s) begin
            out_valid_r <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          if (mul_done_s) begin
            state_r <= S_DONE;
          end else if (!mul_busy_s) begin
            // Multiplier lost its operation; recover rather than hang
            state_r <= S_IDLE;
          end
        end
        S_DONE: begin
          // out_valid is guaranteed low here, so the load never overwrites
          result_r    <= mul_product_s;
          nzcv_r      <= mul_nzcv_s;
          out_valid_r <= 1'b1;
          state_r     <= S_IDLE;
        end
`endif
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flag_n    = nzcv_r[FLAG_N];
  assign flag_z    = nzcv_r[FLAG_Z];
  assign flag_c    = nzcv_r[FLAG_C];
  assign flag_v    = nzcv_r[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe at WIDTH=32. Expected values are
// hand-computed constants. Observed tuple: {out_valid, result, N, Z, C, V}.
module tb_alu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_op;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  logic [36:0] obs;
  int          n_vec;
  int          n_err;

  assign obs = {out_valid, result, flag_n, flag_z, flag_c, flag_v};

  alu_pipe #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .src_a    (src_a),
    .src_b    (src_b),
    .alu_op   (alu_op),
    .carry_in (carry_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flag_n   (flag_n),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_v   (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one edge (in_ready assumed high)
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    carry_in = cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    n_vec++;
    if (obs !== 37'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", obs, 37'h0);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add;
    issue(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    n_vec++;
    if (obs !== {1'b1, 32'h8000_0000, 4'b1001}) begin
      n_err++;
      $display("FAIL add_ovf: got %h want %h", obs, {1'b1, 32'h8000_0000, 4'b1001});
    end
    issue(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0000, 4'b0110}) begin
      n_err++;
      $display("FAIL add_carry: got %h want %h", obs, {1'b1, 32'h0, 4'b0110});
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    // SUB 5-5 then SUB 3-5 on consecutive edges
    alu_op = 3'b011; src_a = 32'd5; src_b = 32'd5; carry_in = 1'b0;
    in_valid = 1'b1;
    tick();
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0000, 4'b0110}) begin
      n_err++;
      $display("FAIL sub_equal: got %h want %h", obs, {1'b1, 32'h0, 4'b0110});
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    src_a = 32'd3;
    tick();
    n_vec++;
    if (obs !== {1'b1, 32'hFFFF_FFFE, 4'b1000}) begin
      n_err++;
      $display("FAIL sub_borrow: got %h want %h", obs, {1'b1, 32'hFFFF_FFFE, 4'b1000});
    end
    src_a = 32'h8000_0000; src_b = 32'h0000_0001;
    tick();
    n_vec++;
    if (obs !== {1'b1, 32'h7FFF_FFFF, 4'b0011}) begin
      n_err++;
      $display("FAIL sub_ovf: got %h want %h", obs, {1'b1, 32'h7FFF_FFFF, 4'b0011});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_logic_adc;
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0000, 4'b0110}) begin
      n_err++;
      $display("FAIL adc_wrap: got %h want %h", obs, {1'b1, 32'h0, 4'b0110});
    end
    issue(3'b100, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b1);
    n_vec++;
    if (obs !== {1'b1, 32'hF00F_F00F, 4'b1000}) begin
      n_err++;
      $display("FAIL eor: got %h want %h", obs, {1'b1, 32'hF00F_F00F, 4'b1000});
    end
    issue(3'b111, 32'h0000_007B, 32'h0000_0000, 1'b1);
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0000, 4'b0100}) begin
      n_err++;
      $display("FAIL mov_zero: got %h want %h", obs, {1'b1, 32'h0, 4'b0100});
    end
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    alu_op = 3'b001; src_a = 32'h0000_00F0; src_b = 32'h0000_0F00;
    in_valid = 1'b1;
    repeat (2) tick();
    n_vec++;
    if (obs !== {1'b1, 32'h0000_F000, 4'b0000}) begin
      n_err++;
      $display("FAIL bp_hold: got %h want %h", obs, {1'b1, 32'h0000_F000, 4'b0000});
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0FF0, 4'b0000}) begin
      n_err++;
      $display("FAIL bp_second: got %h want %h", obs, {1'b1, 32'h0000_0FF0, 4'b0000});
    end
    tick();
    n_vec++;
    if (obs !== {1'b0, 32'h0000_0FF0, 4'b0000}) begin
      n_err++;
      $display("FAIL bp_drain: got %h want %h", obs, {1'b0, 32'h0000_0FF0, 4'b0000});
    end
  endtask

  task automatic test_mul;
    issue(3'b110, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
`ifdef ALU_MUL_EN
    for (int i = 0; i < 33; i++) begin
      n_vec++;
      if ({out_valid, in_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL mul_busy: cycle %0d got %b want 00", i, {out_valid, in_ready});
      end
      tick();
    end
    n_vec++;
    if (obs !== {1'b1, 32'hFFFF_FFFF, 4'b1000}) begin
      n_err++;
      $display("FAIL mul_result: got %h want %h", obs, {1'b1, 32'hFFFF_FFFF, 4'b1000});
    end
`else
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0000, 4'b0100}) begin
      n_err++;
      $display("FAIL mul_disabled: got %h want %h", obs, {1'b1, 32'h0, 4'b0100});
    end
`endif
    tick();
  endtask

  task automatic test_reset_async;
    int stale;
    // Held result must vanish on reset without any clock edge
    out_ready = 1'b0;
    issue(3'b111, 32'h0, 32'hDEAD_BEEF, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({obs, in_ready} !== {37'h0, 1'b1}) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", {obs, in_ready}, {37'h0, 1'b1});
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    // Reset in the middle of a multiply
    issue(3'b110, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    repeat (9) tick();
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL mul_reset: got %b want 01", {out_valid, in_ready});
    end
    tick();
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    n_vec++;
    if ({stale, in_ready} !== {32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL no_stale: got stale=%0d in_ready=%b want 0/1", stale, in_ready);
    end
    issue(3'b010, 32'd2, 32'd3, 1'b0);
    n_vec++;
    if (obs !== {1'b1, 32'h0000_0005, 4'b0000}) begin
      n_err++;
      $display("FAIL post_reset_add: got %h want %h", obs, {1'b1, 32'h5, 4'b0000});
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    in_valid  = 1'b0;
    src_a     = 32'h0;
    src_b     = 32'h0;
    alu_op    = 3'b000;
    carry_in  = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    test_reset();
    test_add();
    test_back_to_back();
    test_logic_adc();
    test_backpressure();
    test_mul();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
